// File: rtl/ac_alu_unit_if.sv
// ac_alu_unit_if: controller <-> accumulator datapath connection.
//   master : controller side (drives dr_in, alu_sel, AC/E strobes;
//            samples ac_out, e_out and combinational status)
//   slave  : ac_alu_unit side
// ovf_sticky exists only when ALU_STICKY_OVF_EN is defined.
interface ac_alu_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] dr_in;
  logic [2:0]       alu_sel;
  logic             ac_ld;
  logic             ac_inr;
  logic             ac_clr;
  logic             e_cmp;
  logic             e_clr;
  logic [WIDTH-1:0] ac_out;
  logic             e_out;
  logic             co;
  logic             z;
  logic             n;
  logic             ovf;
`ifdef ALU_STICKY_OVF_EN
  logic             ovf_sticky;
`endif

  modport master (
    output dr_in, alu_sel, ac_ld, ac_inr, ac_clr, e_cmp, e_clr,
`ifdef ALU_STICKY_OVF_EN
    input  ovf_sticky,
`endif
    input  ac_out, e_out, co, z, n, ovf
  );

  modport slave (
    input  dr_in, alu_sel, ac_ld, ac_inr, ac_clr, e_cmp, e_clr,
`ifdef ALU_STICKY_OVF_EN
    output ovf_sticky,
`endif
    output ac_out, e_out, co, z, n, ovf
  );
endinterface

// File: rtl/ac_alu_unit.sv
// ac_alu_unit: accumulator (AC) and extend bit (E) of the basic computer,
// plus the ALU that feeds them.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears AC, E, sticky flag)
//   bus   ac_alu_unit_if.slave: dr_in, alu_sel, ac_ld/ac_inr/ac_clr,
//         e_cmp/e_clr in; ac_out, e_out, co/z/n/ovf status out
// Optional feature: define ALU_STICKY_OVF_EN to add bus.ovf_sticky, a flag
// set by any overflowing ADD load and cleared only by ac_clr or rst.
// Status outputs are purely combinational so the controller can sample
// them in the same cycle it asserts the strobes.
module ac_alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  ac_alu_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_CMA  = 3'b011;
  localparam logic [2:0] OP_CIR  = 3'b100;
  localparam logic [2:0] OP_CIL  = 3'b101;

  logic [WIDTH-1:0] ac_reg, ac_next;
  logic             e_reg, e_next;

  logic [WIDTH-1:0] and_vec, cma_vec;
  logic [WIDTH-1:0] res;
  logic             co_w, ovf_w;
  logic             e_alu;        // E value produced by ADD/CIR/CIL
  logic             e_alu_valid;  // op produces an E value

  // Bitwise logic-unit slices.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_vec[gi] = ac_reg[gi] & bus.dr_in[gi];
      assign cma_vec[gi] = ~ac_reg[gi];
    end
  endgenerate

  always_comb begin
    res         = ac_reg;
    co_w        = 1'b0;
    ovf_w       = 1'b0;
    e_alu       = e_reg;
    e_alu_valid = 1'b0;
    case (bus.alu_sel)
      OP_ADD: begin
        {co_w, res} = {1'b0, ac_reg} + {1'b0, bus.dr_in};
        // Signed overflow: operands agree in sign, result does not.
        ovf_w       = (ac_reg[WIDTH-1] == bus.dr_in[WIDTH-1]) &&
                      (res[WIDTH-1] != ac_reg[WIDTH-1]);
        e_alu       = co_w;
        e_alu_valid = 1'b1;
      end
      OP_AND:  res = and_vec;
      OP_PASS: res = bus.dr_in;
      OP_CMA:  res = cma_vec;
      OP_CIR: begin
        res         = {e_reg, ac_reg[WIDTH-1:1]};
        e_alu       = ac_reg[0];
        e_alu_valid = 1'b1;
      end
      OP_CIL: begin
        res         = {ac_reg[WIDTH-2:0], e_reg};
        e_alu       = ac_reg[WIDTH-1];
        e_alu_valid = 1'b1;
      end
      default: res = ac_reg;  // 110 reserved, 111 idle: pass AC through
    endcase
  end

  always_comb begin
    if (bus.ac_clr)      ac_next = '0;
    else if (bus.ac_ld)  ac_next = res;
    else if (bus.ac_inr) ac_next = ac_reg + WIDTH'(1);
    else                 ac_next = ac_reg;
  end

  // e_clr/e_cmp win over an E-producing load; AC still loads that cycle.
  always_comb begin
    if (bus.e_clr)                      e_next = 1'b0;
    else if (bus.e_cmp)                 e_next = ~e_reg;
    else if (bus.ac_ld && e_alu_valid)  e_next = e_alu;
    else                                e_next = e_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_reg <= '0;
      e_reg  <= 1'b0;
    end else begin
      ac_reg <= ac_next;
      e_reg  <= e_next;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_reg, sticky_next;

  // ac_clr beats a same-edge set.
  always_comb begin
    if (bus.ac_clr)                                         sticky_next = 1'b0;
    else if (bus.ac_ld && (bus.alu_sel == OP_ADD) && ovf_w) sticky_next = 1'b1;
    else                                                    sticky_next = sticky_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_reg <= 1'b0;
    else     sticky_reg <= sticky_next;
  end

  assign bus.ovf_sticky = sticky_reg;
`endif

  assign bus.ac_out = ac_reg;
  assign bus.e_out  = e_reg;
  assign bus.co     = co_w;
  assign bus.ovf    = ovf_w;
  assign bus.z      = (res == '0);
  assign bus.n      = res[WIDTH-1];

endmodule

// File: tb/tb_ac_alu_unit.sv
// tb_ac_alu_unit: directed and randomized checks of ac_alu_unit against a
// behavioural model computed with plain integer arithmetic.
module tb_ac_alu_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ac_alu_unit_if #(.WIDTH(W)) bus_if ();

  ac_alu_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] m_ac = '0;
  logic         m_e = 1'b0;
  logic         m_sticky = 1'b0;

  // Expected ALU behaviour from the operation table, using integers.
  function automatic void model_alu(input logic [2:0] sel, input logic [W-1:0] ac,
                                    input logic [W-1:0] dr, input logic e,
                                    output logic [W-1:0] res, output logic co,
                                    output logic ovf, output logic e_new,
                                    output logic e_valid);
    int unsigned usum;
    int ssum;
    res = ac; co = 1'b0; ovf = 1'b0; e_new = e; e_valid = 1'b0;
    case (sel)
      3'd0: begin
        usum = int'(ac) + int'(dr);
        res  = usum[W-1:0];
        co   = (usum >= (1 << W));
        ssum = int'($signed(ac)) + int'($signed(dr));
        ovf  = (ssum > 32767) || (ssum < -32768);
        e_new = co; e_valid = 1'b1;
      end
      3'd1: res = ac & dr;
      3'd2: res = dr;
      3'd3: res = ~ac;
      3'd4: begin
        res = W'((int'(ac) / 2) + (e ? 32768 : 0));
        e_new = ac[0]; e_valid = 1'b1;
      end
      3'd5: begin
        res = W'((int'(ac) * 2) % 65536 + (e ? 1 : 0));
        e_new = (ac >= 16'h8000); e_valid = 1'b1;
      end
      default: res = ac;
    endcase
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [W-1:0] dr,
                       input logic ld, input logic inr, input logic clr,
                       input logic ecmp, input logic eclr);
    bus_if.alu_sel = sel; bus_if.dr_in = dr;
    bus_if.ac_ld = ld; bus_if.ac_inr = inr; bus_if.ac_clr = clr;
    bus_if.e_cmp = ecmp; bus_if.e_clr = eclr;
    #2;
  endtask

  // Advance one edge, updating the model from the currently driven inputs.
  task automatic clock_edge();
    logic [W-1:0] r; logic c, o, ea, ev;
    model_alu(bus_if.alu_sel, m_ac, bus_if.dr_in, m_e, r, c, o, ea, ev);
    if (bus_if.e_clr)                     m_e = 1'b0;
    else if (bus_if.e_cmp)                m_e = ~m_e;
    else if (bus_if.ac_ld && ev)          m_e = ea;
    if (bus_if.ac_clr)                    m_sticky = 1'b0;
    else if (bus_if.ac_ld && bus_if.alu_sel == 3'd0 && o) m_sticky = 1'b1;
    if (bus_if.ac_clr)       m_ac = '0;
    else if (bus_if.ac_ld)   m_ac = r;
    else if (bus_if.ac_inr)  m_ac = m_ac + 16'd1;
    $display("txn sel=%b dr=%h ld=%b inr=%b clr=%b ecmp=%b eclr=%b -> model ac=%h e=%b",
             bus_if.alu_sel, bus_if.dr_in, bus_if.ac_ld, bus_if.ac_inr,
             bus_if.ac_clr, bus_if.e_cmp, bus_if.e_clr, m_ac, m_e);
    @(posedge clk); #1;
  endtask

  task automatic load_ac(input logic [W-1:0] v);
    drive(3'b010, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
  endtask

  task automatic set_e(input logic v);
    drive(3'b111, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clock_edge();
    if (v) begin
      drive(3'b111, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clock_edge();
    end
  endtask

  task automatic test_reset();
    // Power-on reset state
    drive(3'b111, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.ac_out !== 16'h0000 || bus_if.e_out !== 1'b0) begin
      n_bad++; $display("FAIL por_regs ac=%h e=%b want 0000/0", bus_if.ac_out, bus_if.e_out); end
    n_cmp++; if ({bus_if.z, bus_if.n, bus_if.co, bus_if.ovf} !== 4'b1000) begin
      n_bad++; $display("FAIL por_status zncv=%b want 1000", {bus_if.z, bus_if.n, bus_if.co, bus_if.ovf}); end
    @(posedge clk); #1; rst = 1'b0;
    m_ac = '0; m_e = 1'b0; m_sticky = 1'b0;
    // Mid-cycle asynchronous reset with AC=1234, E=1
    load_ac(16'h1234);
    set_e(1'b1);
    n_cmp++; if (bus_if.ac_out !== 16'h1234 || bus_if.e_out !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset ac=%h e=%b want 1234/1", bus_if.ac_out, bus_if.e_out); end
    drive(3'b111, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; #1;
    n_cmp++; if (bus_if.ac_out !== 16'h0000 || bus_if.e_out !== 1'b0 || bus_if.z !== 1'b1) begin
      n_bad++; $display("FAIL async_reset ac=%h e=%b z=%b want 0000/0/1", bus_if.ac_out, bus_if.e_out, bus_if.z); end
    // Strobes ignored while rst is high
    drive(3'b010, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (bus_if.ac_out !== 16'h0000 || bus_if.e_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold ac=%h e=%b want 0000/0", bus_if.ac_out, bus_if.e_out); end
    drive(3'b111, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_ac = '0; m_e = 1'b0; m_sticky = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    load_ac(16'h7FFF); set_e(1'b0);
    drive(3'b000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus_if.ovf, bus_if.n, bus_if.co} !== 3'b110) begin
      n_bad++; $display("FAIL add_ovf_status ovf/n/co=%b want 110", {bus_if.ovf, bus_if.n, bus_if.co}); end
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h8000 || bus_if.e_out !== 1'b0) begin
      n_bad++; $display("FAIL add_ovf_regs ac=%h e=%b want 8000/0", bus_if.ac_out, bus_if.e_out); end
    load_ac(16'hFFFF);
    drive(3'b000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus_if.co, bus_if.ovf} !== 2'b10) begin
      n_bad++; $display("FAIL add_carry_status co/ovf=%b want 10", {bus_if.co, bus_if.ovf}); end
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0001 || bus_if.e_out !== 1'b1) begin
      n_bad++; $display("FAIL add_carry_regs ac=%h e=%b want 0001/1", bus_if.ac_out, bus_if.e_out); end
  endtask

  task automatic test_circulate();
    load_ac(16'h8001); set_e(1'b0);
    drive(3'b101, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0002 || bus_if.e_out !== 1'b1) begin
      n_bad++; $display("FAIL cil ac=%h e=%b want 0002/1", bus_if.ac_out, bus_if.e_out); end
    drive(3'b100, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h8001 || bus_if.e_out !== 1'b0) begin
      n_bad++; $display("FAIL cir ac=%h e=%b want 8001/0", bus_if.ac_out, bus_if.e_out); end
  endtask

  task automatic test_flags();
    load_ac(16'h0000);
    drive(3'b011, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus_if.n, bus_if.z} !== 2'b10) begin
      n_bad++; $display("FAIL cma_flags n/z=%b want 10", {bus_if.n, bus_if.z}); end
    drive(3'b010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.z !== 1'b1) begin
      n_bad++; $display("FAIL pass_zero z=%b want 1", bus_if.z); end
    drive(3'b010, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0000) begin
      n_bad++; $display("FAIL no_strobe_hold ac=%h want 0000", bus_if.ac_out); end
  endtask

  task automatic test_priority();
    load_ac(16'h0005);
    drive(3'b010, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0000) begin
      n_bad++; $display("FAIL clr_priority ac=%h want 0000", bus_if.ac_out); end
    load_ac(16'hFFFF); set_e(1'b1);
    drive(3'b000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0001 || bus_if.e_out !== 1'b0) begin
      n_bad++; $display("FAIL eclr_over_add ac=%h e=%b want 0001/0", bus_if.ac_out, bus_if.e_out); end
    load_ac(16'hFFFF);
    drive(3'b111, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ac_out !== 16'h0000) begin
      n_bad++; $display("FAIL inr_wrap ac=%h want 0000", bus_if.ac_out); end
  endtask

  task automatic test_random();
    logic [W-1:0] r; logic c, o, ea, ev;
    logic [2:0] sel; logic [W-1:0] dr;
    for (int i = 0; i < 200; i++) begin
      sel = 3'($urandom_range(0, 7));
      dr  = (i % 8 == 0) ? 16'h0000 : W'($urandom);
      drive(sel, dr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
      model_alu(sel, m_ac, dr, m_e, r, c, o, ea, ev);
      n_cmp++; if ({bus_if.co, bus_if.ovf, bus_if.z, bus_if.n} !== {c, o, (r == '0), r[W-1]}) begin
        n_bad++; $display("FAIL rnd_status[%0d] co/ovf/z/n=%b want %b", i,
                          {bus_if.co, bus_if.ovf, bus_if.z, bus_if.n}, {c, o, (r == '0), r[W-1]}); end
      clock_edge();
      n_cmp++; if (bus_if.ac_out !== m_ac || bus_if.e_out !== m_e) begin
        n_bad++; $display("FAIL rnd_regs[%0d] ac=%h e=%b want %h/%b", i, bus_if.ac_out, bus_if.e_out, m_ac, m_e); end
`ifdef ALU_STICKY_OVF_EN
      n_cmp++; if (bus_if.ovf_sticky !== m_sticky) begin
        n_bad++; $display("FAIL rnd_sticky[%0d] got %b want %b", i, bus_if.ovf_sticky, m_sticky); end
`endif
    end
  endtask

`ifdef ALU_STICKY_OVF_EN
  task automatic test_sticky();
    drive(3'b111, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clock_edge();
    load_ac(16'h7FFF);
    drive(3'b000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ovf_sticky !== 1'b1) begin
      n_bad++; $display("FAIL sticky_set got %b want 1", bus_if.ovf_sticky); end
    drive(3'b000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    drive(3'b000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ovf_sticky !== 1'b1) begin
      n_bad++; $display("FAIL sticky_hold got %b want 1", bus_if.ovf_sticky); end
    drive(3'b111, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clock_edge();
    n_cmp++; if (bus_if.ovf_sticky !== 1'b0) begin
      n_bad++; $display("FAIL sticky_clr got %b want 0", bus_if.ovf_sticky); end
  endtask
`endif

  initial begin
    bus_if.alu_sel = 3'b111; bus_if.dr_in = '0;
    bus_if.ac_ld = 1'b0; bus_if.ac_inr = 1'b0; bus_if.ac_clr = 1'b0;
    bus_if.e_cmp = 1'b0; bus_if.e_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_circulate();
    test_flags();
    test_priority();
`ifdef ALU_STICKY_OVF_EN
    test_sticky();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
